vga_bar_pattern_gen: RTL and testbench
======================================

VGA_BAR_PATTERN_GEN -- requirements
Module: vga_bar_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_BARS, default 7, number of colour bars, legal range 2..8.
REQ-002 SHALL have parameter COLOR_W, default 4, bits per colour channel, legal range 4..8.
REQ-003 SHALL have parameter CNT_W, default 32, width of all count and geometry ports.
REQ-004 SHALL have port clock, input, 1, pixel clock; all logic in this single domain.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pixel_count, input, CNT_W, current horizontal position from the VGA controller.
REQ-007 SHALL have port line_count, input, CNT_W, current vertical position from the VGA controller.
REQ-008 SHALL have ports h_back_porch, h_visible_area, v_back_porch, v_visible_area, each input, CNT_W, timing geometry.
REQ-009 SHALL have port mode, input, 2, pattern select: 00 vertical bars, 01 horizontal bars, 10 checkerboard, 11 scrolling vertical bars.
REQ-010 SHALL have ports red, grn, blu, each output, COLOR_W, registered pixel colour.
REQ-011 SHALL have port bar_index, output, 3, palette index of the pixel currently on red/grn/blu.
REQ-012 SHALL have port geom_valid, output, 1, high once bar widths for the current geometry are computed.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse when pixel_count==0 and line_count==0 are sampled.

Function
REQ-014 SHALL define visible pixels as line_count in [v_back_porch, v_back_porch+v_visible_area) and pixel_count in [h_back_porch, h_back_porch+h_visible_area), with exclusive upper bounds.
REQ-015 SHALL, on frame_start, latch all four geometry inputs and the mode input; the latched values SHALL stay fixed for the whole frame.
REQ-016 SHALL compute hbw = h_visible_area/NUM_BARS and vbw = v_visible_area/NUM_BARS with an iterative divider started at frame_start and completing in at most CNT_W+2 cycles.
REQ-017 SHALL keep the previous hbw/vbw until the divider completes; geom_valid SHALL rise on completion.
REQ-018 SHALL force hbw or vbw to 1 when the computed quotient is 0.
REQ-019 SHALL set the horizontal bar index hidx to 0 on the first visible pixel of each line, then increment it after every hbw pixels, saturating at NUM_BARS-1 so remainder pixels join the last bar.
REQ-020 SHALL derive the vertical index vidx the same way from visible lines and vbw.
REQ-021 SHALL select the palette index as: mode 00 hidx; mode 01 vidx; mode 10 (hidx+vidx) mod NUM_BARS; mode 11 hidx computed from visible pixel position (x+scroll) mod h_visible_area.
REQ-022 SHALL hold the scroll register at 0 after reset, increment it by 1 at each frame_start, and wrap it to 0 at h_visible_area.
REQ-023 SHALL use the palette 0 90D violet, 1 408 indigo, 2 00F blue, 3 0F0 green, 4 FF0 yellow, 5 F70 orange, 6 F00 red, 7 FFF white; each 4-bit nibble occupies the channel MSBs, with lower bits zero.
REQ-024 SHALL force the last bar (index NUM_BARS-1) to red F00, whatever NUM_BARS is.
REQ-025 SHALL drive outputs one clock after (pixel_count, line_count) are sampled; the latency is exactly 1 cycle.
REQ-026 SHALL output black and bar_index 0 for non-visible pixels and whenever geom_valid is low.

Reset
REQ-027 SHALL, while reset_n is low, immediately clear red, grn, blu, bar_index, frame_start, geom_valid, scroll, counters and the divider.
REQ-028 SHALL, after a mid-frame reset, output black until the next frame_start followed by divider completion.

Configuration
REQ-029 SHALL compile scrolling logic only when macro VGA_PATTERN_SCROLL_EN is defined; otherwise the scroll register is absent and mode 11 behaves exactly as mode 00.

Verification
REQ-030 SHALL cover 800x600: HBP=64, HVA=800, VBP=23, VVA=600, mode 00 -> hbw=114; pixel 64 gives 90D next cycle, pixel 178 gives 408, pixel 748 gives F00 (last bar 116 pixels), pixel 863 gives F00, pixel 864 gives 000.
REQ-031 SHALL cover mode 01, same geometry -> vbw=85; line 23 gives violet, line 108 gives indigo, line 622 gives red, line 623 gives black.
REQ-032 SHALL cover mode 11 with macro defined, after 3 frames -> pixel 64 shows bar of x=3 (violet); x=111 gives indigo; without macro the output is identical to mode 00.
REQ-033 SHALL cover reset_n pulsed low mid-line at pixel 300 -> outputs 000 and geom_valid=0 immediately, black until the next frame plus at most 34 cycles.
REQ-034 SHALL cover NUM_BARS=4, HVA=3 -> hbw forced to 1; pixels show violet, indigo, blue, then black.
REQ-035 SHALL cover mode changed from 00 to 10 mid-frame -> the pattern is unchanged until the next frame_start.

Source files
------------

// File: rtl/vga_bar_pattern_gen.sv
// rtl/vga_bar_pattern_gen.sv - colour bar / checkerboard pattern generator for a VGA pixel stream
// Scrolling bars (mode 11) are compiled in only with `define VGA_PATTERN_SCROLL_EN.
module vga_bar_pattern_gen #(
  parameter int NUM_BARS = 7,
  parameter int COLOR_W  = 4,
  parameter int CNT_W    = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [CNT_W-1:0]   pixel_count,
  input  logic [CNT_W-1:0]   line_count,
  input  logic [CNT_W-1:0]   h_back_porch,
  input  logic [CNT_W-1:0]   h_visible_area,
  input  logic [CNT_W-1:0]   v_back_porch,
  input  logic [CNT_W-1:0]   v_visible_area,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] grn,
  output logic [COLOR_W-1:0] blu,
  output logic [2:0]         bar_index,
  output logic               geom_valid,
  output logic               frame_start
);

  localparam int         DCW  = $clog2(CNT_W + 1);
  localparam logic [2:0] LAST = 3'(NUM_BARS - 1);

  logic [CNT_W-1:0]   hbp_q, hva_q, vbp_q, vva_q, hbw_q, vbw_q;
  logic [1:0]         mode_q;
  logic               busy_q, geom_valid_q, frame_start_q;
  logic [DCW-1:0]     div_cnt_q;
  logic [2:0]         rem_h_q, rem_v_q;
  logic [CNT_W-1:0]   quo_h_q, quo_v_q;
  logic [2:0]         hidx_q, vidx_q, hidx_d, vidx_d, pal_idx, bar_index_q;
  logic [CNT_W-1:0]   hcnt_q, vcnt_q, hcnt_d, vcnt_d;
  logic [COLOR_W-1:0] red_q, grn_q, blu_q;
  logic [CNT_W+2:0]   div_h, div_v;
  logic [CNT_W-1:0]   hbw_new, vbw_new;
  logic [CNT_W:0]     h_end, v_end;
  logic               sof, vis_h, vis_v, h_first, div_done;
  logic [3:0]         sum_hv;
  logic [11:0]        rgb;

  // One restoring-division step by the constant NUM_BARS; remainder never exceeds 7.
  function automatic logic [CNT_W+2:0] div_step(input logic [2:0] rem, input logic [CNT_W-1:0] quo);
    logic [3:0] sh;
    sh = {rem, quo[CNT_W-1]};
    if (sh >= 4'(NUM_BARS)) div_step = {3'(sh - 4'(NUM_BARS)), quo[CNT_W-2:0], 1'b1};
    else                    div_step = {sh[2:0], quo[CNT_W-2:0], 1'b0};
  endfunction

  // Advance a bar index/count pair by one position; the last bar absorbs the remainder.
  function automatic logic [CNT_W+2:0] bar_step(input logic [2:0] idx, input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] bw);
    if (idx == LAST)                 bar_step = {idx, cnt};
    else if (cnt >= bw - CNT_W'(1)) bar_step = {idx + 3'd1, {CNT_W{1'b0}}};
    else                             bar_step = {idx, cnt + CNT_W'(1)};
  endfunction

  function automatic logic [11:0] palette(input logic [2:0] idx);
    if (idx == LAST) return 12'hF00;
    case (idx)
      3'd0:    return 12'h90D;
      3'd1:    return 12'h408;
      3'd2:    return 12'h00F;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hFF0;
      3'd5:    return 12'hF70;
      3'd6:    return 12'hF00;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic logic [COLOR_W-1:0] expand(input logic [3:0] nib);
    return COLOR_W'(nib) << (COLOR_W - 4);
  endfunction

  assign sof      = (pixel_count == '0) && (line_count == '0);
  assign h_end    = {1'b0, hbp_q} + {1'b0, hva_q};
  assign v_end    = {1'b0, vbp_q} + {1'b0, vva_q};
  assign vis_h    = (pixel_count >= hbp_q) && ({1'b0, pixel_count} < h_end);
  assign vis_v    = (line_count >= vbp_q) && ({1'b0, line_count} < v_end);
  assign h_first  = (pixel_count == hbp_q);
  assign div_h    = div_step(rem_h_q, quo_h_q);
  assign div_v    = div_step(rem_v_q, quo_v_q);
  assign hbw_new  = (div_h[CNT_W-1:0] == '0) ? CNT_W'(1) : div_h[CNT_W-1:0];
  assign vbw_new  = (div_v[CNT_W-1:0] == '0) ? CNT_W'(1) : div_v[CNT_W-1:0];
  assign div_done = busy_q && (div_cnt_q == DCW'(1)) && !sof;

  always_comb begin
    {hidx_d, hcnt_d} = {hidx_q, hcnt_q};
    {vidx_d, vcnt_d} = {vidx_q, vcnt_q};
    if (h_first)    {hidx_d, hcnt_d} = '0;
    else if (vis_h) {hidx_d, hcnt_d} = bar_step(hidx_q, hcnt_q, hbw_q);
    // The vertical counter advances once per line, on its first visible pixel.
    if (h_first && vis_v) begin
      if (line_count == vbp_q) {vidx_d, vcnt_d} = '0;
      else                     {vidx_d, vcnt_d} = bar_step(vidx_q, vcnt_q, vbw_q);
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  logic [CNT_W-1:0] scroll_q, spos_q, scnt_q, sst_cnt_q, spos_d, scnt_d;
  logic [2:0]       sidx_q, sst_idx_q, sidx_d;

  always_comb begin
    spos_d           = spos_q;
    {sidx_d, scnt_d} = {sidx_q, scnt_q};
    if (h_first) begin
      spos_d           = scroll_q;
      {sidx_d, scnt_d} = {sst_idx_q, sst_cnt_q};
    end else if (vis_h) begin
      if (spos_q >= hva_q - CNT_W'(1)) begin
        spos_d           = '0;
        {sidx_d, scnt_d} = '0;
      end else begin
        spos_d           = spos_q + CNT_W'(1);
        {sidx_d, scnt_d} = bar_step(sidx_q, scnt_q, hbw_q);
      end
    end
  end

  // Bar position of the scroll offset is stepped once per frame with the fresh bar width.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scroll_q  <= '0;
      spos_q    <= '0;
      scnt_q    <= '0;
      sidx_q    <= '0;
      sst_cnt_q <= '0;
      sst_idx_q <= '0;
    end else begin
      spos_q <= spos_d;
      sidx_q <= sidx_d;
      scnt_q <= scnt_d;
      if (sof)
        scroll_q <= ({1'b0, scroll_q} + 1'b1 >= {1'b0, h_visible_area}) ? '0 : scroll_q + CNT_W'(1);
      if (div_done) begin
        if (scroll_q == '0) {sst_idx_q, sst_cnt_q} <= '0;
        else                {sst_idx_q, sst_cnt_q} <= bar_step(sst_idx_q, sst_cnt_q, hbw_new);
      end
    end
  end
`endif

  always_comb begin
    sum_hv = {1'b0, hidx_d} + {1'b0, vidx_d};
    case (mode_q)
      2'b01:   pal_idx = vidx_d;
      2'b10:   pal_idx = 3'((sum_hv >= 4'(NUM_BARS)) ? sum_hv - 4'(NUM_BARS) : sum_hv);
`ifdef VGA_PATTERN_SCROLL_EN
      2'b11:   pal_idx = sidx_d;
`endif
      default: pal_idx = hidx_d;
    endcase
    rgb = palette(pal_idx);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {hbp_q, hva_q, vbp_q, vva_q} <= '0;
      {hbw_q, vbw_q}               <= '0;
      mode_q        <= '0;
      busy_q        <= 1'b0;
      geom_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      div_cnt_q     <= '0;
      {rem_h_q, rem_v_q, quo_h_q, quo_v_q} <= '0;
      {hidx_q, vidx_q, hcnt_q, vcnt_q}     <= '0;
      {red_q, grn_q, blu_q, bar_index_q}   <= '0;
    end else begin
      frame_start_q <= sof;
      hidx_q <= hidx_d;
      hcnt_q <= hcnt_d;
      vidx_q <= vidx_d;
      vcnt_q <= vcnt_d;
      if (sof) begin
        hbp_q     <= h_back_porch;
        hva_q     <= h_visible_area;
        vbp_q     <= v_back_porch;
        vva_q     <= v_visible_area;
        mode_q    <= mode;
        busy_q    <= 1'b1;
        div_cnt_q <= DCW'(CNT_W);
        rem_h_q   <= '0;
        rem_v_q   <= '0;
        quo_h_q   <= h_visible_area;
        quo_v_q   <= v_visible_area;
      end else if (busy_q) begin
        {rem_h_q, quo_h_q} <= div_h;
        {rem_v_q, quo_v_q} <= div_v;
        div_cnt_q          <= div_cnt_q - DCW'(1);
        if (div_done) begin
          busy_q       <= 1'b0;
          hbw_q        <= hbw_new;
          vbw_q        <= vbw_new;
          geom_valid_q <= 1'b1;
        end
      end
      if (vis_h && vis_v && geom_valid_q) begin
        red_q       <= expand(rgb[11:8]);
        grn_q       <= expand(rgb[7:4]);
        blu_q       <= expand(rgb[3:0]);
        bar_index_q <= pal_idx;
      end else begin
        {red_q, grn_q, blu_q, bar_index_q} <= '0;
      end
    end
  end

  assign red         = red_q;
  assign grn         = grn_q;
  assign blu         = blu_q;
  assign bar_index   = bar_index_q;
  assign geom_valid  = geom_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_bar_pattern_gen.sv
// tb/tb_vga_bar_pattern_gen.sv - scoreboard bench for vga_bar_pattern_gen (7-bar/4-bit and 4-bar/8-bit instances)
module tb_vga_bar_pattern_gen;
  localparam int CNT_W = 32;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [CNT_W-1:0] pixel_count, line_count;
  logic [CNT_W-1:0] h_back_porch, h_visible_area, v_back_porch, v_visible_area;
  logic [1:0]       mode;
  logic [3:0]       red7, grn7, blu7;
  logic [7:0]       red4, grn4, blu4;
  logic [2:0]       bi7, bi4;
  logic             gv7, gv4, fs7, fs4;

  always #5 clock = ~clock;

  vga_bar_pattern_gen u_dut7 (
    .clock(clock), .reset_n(reset_n), .pixel_count(pixel_count), .line_count(line_count),
    .h_back_porch(h_back_porch), .h_visible_area(h_visible_area),
    .v_back_porch(v_back_porch), .v_visible_area(v_visible_area), .mode(mode),
    .red(red7), .grn(grn7), .blu(blu7), .bar_index(bi7), .geom_valid(gv7), .frame_start(fs7)
  );

  vga_bar_pattern_gen #(.NUM_BARS(4), .COLOR_W(8), .CNT_W(CNT_W)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .pixel_count(pixel_count), .line_count(line_count),
    .h_back_porch(h_back_porch), .h_visible_area(h_visible_area),
    .v_back_porch(v_back_porch), .v_visible_area(v_visible_area), .mode(mode),
    .red(red4), .grn(grn4), .blu(blu4), .bar_index(bi4), .geom_valid(gv4), .frame_start(fs4)
  );

  typedef struct { int px; int ln; int e7; int e4; } exp_t;
  exp_t sb[$];
  int   n_pass = 0, n_fail = 0, n_total = 0;
  int   m_hbp, m_hva, m_vbp, m_vva, m_mode, m_scroll;
  bit   m_valid;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bar_of(int pos, int area, int nb);
    int bw, b;
    bw = area / nb;
    if (bw == 0) bw = 1;
    b = pos / bw;
    return (b > nb - 1) ? nb - 1 : b;
  endfunction

  // Expected palette index for a sampled pixel, -1 meaning black.
  function automatic int exp_idx(int nb, int px, int ln);
    int x, y, h, v;
    x = px - m_hbp;
    y = ln - m_vbp;
    if (!m_valid || x < 0 || x >= m_hva || y < 0 || y >= m_vva) return -1;
    h = bar_of(x, m_hva, nb);
    v = bar_of(y, m_vva, nb);
    case (m_mode)
      1: return v;
      2: return (h + v) % nb;
`ifdef VGA_PATTERN_SCROLL_EN
      3: return bar_of((x + m_scroll) % m_hva, m_hva, nb);
`endif
      default: return h;
    endcase
  endfunction

  function automatic logic [11:0] rgb_of(int idx, int nb);
    if (idx < 0) return 12'h000;
    if (idx == nb - 1) return 12'hF00;
    case (idx)
      0: return 12'h90D;
      1: return 12'h408;
      2: return 12'h00F;
      3: return 12'h0F0;
      4: return 12'hFF0;
      5: return 12'hF70;
      6: return 12'hF00;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic logic [31:0] pack7(int idx);
    logic [11:0] c;
    logic [2:0]  b;
    c = rgb_of(idx, 7);
    b = (idx < 0) ? 3'd0 : 3'(idx);
    return {17'd0, b, c};
  endfunction

  function automatic logic [31:0] pack4(int idx);
    logic [11:0] c;
    logic [2:0]  b;
    c = rgb_of(idx, 4);
    b = (idx < 0) ? 3'd0 : 3'(idx);
    return {5'd0, b, c[11:8], 4'h0, c[7:4], 4'h0, c[3:0], 4'h0};
  endfunction

  task automatic drive(int px, int ln);
    exp_t e;
    pixel_count = px;
    line_count  = ln;
    e.px = px;
    e.ln = ln;
    e.e7 = exp_idx(7, px, ln);
    e.e4 = exp_idx(4, px, ln);
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check($sformatf("pix7 px=%0d ln=%0d", e.px, e.ln), {17'd0, bi7, red7, grn7, blu7}, pack7(e.e7));
    check($sformatf("pix4 px=%0d ln=%0d", e.px, e.ln), {5'd0, bi4, red4, grn4, blu4}, pack4(e.e4));
  endtask

  task automatic start_frame();
    bit was_valid;
    was_valid = m_valid;
    drive(0, 0);
    check("frame_start7", 32'(fs7), 1);
    check("frame_start4", 32'(fs4), 1);
    m_hbp  = int'(h_back_porch);
    m_hva  = int'(h_visible_area);
    m_vbp  = int'(v_back_porch);
    m_vva  = int'(v_visible_area);
    m_mode = int'(mode);
`ifdef VGA_PATTERN_SCROLL_EN
    m_scroll = (m_scroll + 1 >= m_hva) ? 0 : m_scroll + 1;
`endif
    drive(1, 0);
    check("frame_start_pulse", 32'(fs7), 0);
    if (!was_valid) check("geom_valid_early", 32'(gv7), 0);
    for (int i = 0; i < CNT_W + 1; i++) drive(1, 0);
    check("geom_valid7_bound", 32'(gv7), 1);
    check("geom_valid4_bound", 32'(gv4), 1);
    m_valid = 1'b1;
  endtask

  task automatic sweep_line(int ln);
    for (int p = 0; p <= m_hbp + m_hva + 1; p++) drive(p, ln);
  endtask

  task automatic sparse_line(int ln);
    drive(m_hbp - 1, ln);
    drive(m_hbp, ln);
    drive(m_hbp + 1, ln);
  endtask

  initial begin
    reset_n        = 1'b0;
    pixel_count    = 5;
    line_count     = 5;
    h_back_porch   = 64;
    h_visible_area = 800;
    v_back_porch   = 23;
    v_visible_area = 600;
    mode           = 2'b00;
    m_valid        = 1'b0;
    m_scroll       = 0;
    {m_hbp, m_hva, m_vbp, m_vva, m_mode} = {32'd64, 32'd800, 32'd23, 32'd600, 32'd0};
    repeat (3) @(posedge clock);
    #1;
    check("rst_out7", {17'd0, bi7, red7, grn7, blu7}, 0);
    check("rst_out4", {5'd0, bi4, red4, grn4, blu4}, 0);
    check("rst_gv7", 32'(gv7), 0);
    check("rst_gv4", 32'(gv4), 0);
    check("rst_fs7", 32'(fs7), 0);
    check("rst_fs4", 32'(fs4), 0);
    reset_n = 1'b1;

    for (int p = 60; p < 70; p++) drive(p, 23);

    start_frame();
    sweep_line(23);

    mode = 2'b01;
    start_frame();
    for (int ln = 0; ln < 630; ln++) begin
      if (ln == 300) mode = 2'b10;
      sparse_line(ln);
    end

    start_frame();
    for (int ln = 0; ln < 630; ln++) begin
      if (ln == 23 || ln == 200 || ln == 400 || ln == 622) sweep_line(ln);
      else sparse_line(ln);
    end

    mode = 2'b00;
    start_frame();
    for (int p = 0; p <= 300; p++) drive(p, 23);
    reset_n = 1'b0;
    #1;
    check("rst_mid_out7", {17'd0, bi7, red7, grn7, blu7}, 0);
    check("rst_mid_out4", {5'd0, bi4, red4, grn4, blu4}, 0);
    check("rst_mid_gv7", 32'(gv7), 0);
    check("rst_mid_gv4", 32'(gv4), 0);
    m_valid  = 1'b0;
    m_scroll = 0;
    drive(301, 23);
    drive(302, 23);
    reset_n = 1'b1;
    for (int p = 303; p <= 866; p++) drive(p, 23);

    mode = 2'b11;
    for (int f = 0; f < 3; f++) begin
      start_frame();
      sweep_line(23);
    end

    mode           = 2'b00;
    h_visible_area = 3;
    start_frame();
    for (int p = 0; p < 70; p++) drive(p, 23);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
